// File: rtl/processor_status_reg_pkg.sv
// Shared CPU definitions for the 6502 status register: flag bit positions,
// the reset value of P and the P vector type.
package processor_status_reg_pkg;

  localparam int unsigned P_W = 8;

  typedef logic [P_W-1:0] p_t;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_I = 2;
  localparam int unsigned FLAG_D = 3;
  localparam int unsigned FLAG_B = 4;
  localparam int unsigned FLAG_U = 5;
  localparam int unsigned FLAG_V = 6;
  localparam int unsigned FLAG_N = 7;

  localparam p_t RESET_P_DEFAULT = 8'h34;

  // B is not stored in P and U always reads as one.
  function automatic p_t p_canon(input p_t p);
    p_t r;
    r         = p;
    r[FLAG_U] = 1'b1;
    r[FLAG_B] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/processor_status_reg_so_edge_detect.sv
// SO pin synchronizer plus one-cycle falling-edge pulse, both advancing only on CE.
// Used by processor_status_reg when SO_PIN_EN is defined.
module processor_status_reg_so_edge_detect #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic so_n,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchronizer chain and previous-sample register, idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else if (ce) begin
      sync_q[0] <= so_n;
      for (int unsigned k = 1; k < STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign fall_c = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/processor_status_reg.sv
// 6502 processor status register P (N V - B D I Z C) with per-flag load strobes,
// boundary-delayed interrupt mask and DB push path. Optional SO pin: SO_PIN_EN.
module processor_status_reg
  import processor_status_reg_pkg::*;
#(
  parameter p_t          RESET_P        = RESET_P_DEFAULT,
  parameter int unsigned SO_SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic [7:0] DB_IN,
  input  logic       AVR_IN,
  input  logic       ACR_IN,
  input  logic       HC_IN,
  input  logic       IR5,
  input  logic       DB_TO_P,
  input  logic       ACR_TO_C,
  input  logic       IR5_TO_C,
  input  logic       DB0_TO_C,
  input  logic       AVR_TO_V,
  input  logic       DB6_TO_V,
  input  logic       ZERO_V,
  input  logic       DBZ_TO_Z,
  input  logic       DB7_TO_N,
  input  logic       IR5_TO_I,
  input  logic       ONE_TO_I,
  input  logic       IR5_TO_D,
  input  logic       SYNC,
  input  logic       BRK_PUSH,
  input  logic       P_TO_DB,
`ifdef SO_PIN_EN
  input  logic       SO_N,
`endif
  output logic [7:0] DB_OUT,
  output logic       DB_OE,
  output logic [7:0] P_OUT,
  output logic       I_MASK,
  output logic       D_FLAG,
  output logic       HC_LAST
);

  p_t   p_q;
  p_t   p_d;
  logic i_mask_q;
  logic hc_last_q;
  logic so_fall;

`ifdef SO_PIN_EN
  processor_status_reg_so_edge_detect #(
    .STAGES (SO_SYNC_STAGES)
  ) u_so_edge (
    .clk    (CLK),
    .rst    (RST),
    .ce     (CE),
    .so_n   (SO_N),
    .fall_c (so_fall)
  );
`else
  assign so_fall = 1'b0;
`endif

  // Next P: lowest-priority source applied first, higher ones override.
  always_comb begin
    p_d = p_q;
    if (DB_TO_P) begin
      p_d[FLAG_N] = DB_IN[7];
      p_d[FLAG_V] = DB_IN[6];
      p_d[FLAG_D] = DB_IN[3];
      p_d[FLAG_I] = DB_IN[2];
      p_d[FLAG_Z] = DB_IN[1];
      p_d[FLAG_C] = DB_IN[0];
    end
    if (IR5_TO_C) p_d[FLAG_C] = IR5;
    if (DB0_TO_C) p_d[FLAG_C] = DB_IN[0];
    if (ACR_TO_C) p_d[FLAG_C] = ACR_IN;
    if (DB6_TO_V) p_d[FLAG_V] = DB_IN[6];
    if (AVR_TO_V) p_d[FLAG_V] = AVR_IN;
    if (ZERO_V)   p_d[FLAG_V] = 1'b0;
    if (so_fall)  p_d[FLAG_V] = 1'b1;
    if (DBZ_TO_Z) p_d[FLAG_Z] = (DB_IN == 8'h00);
    if (DB7_TO_N) p_d[FLAG_N] = DB_IN[7];
    if (IR5_TO_I) p_d[FLAG_I] = IR5;
    if (ONE_TO_I) p_d[FLAG_I] = 1'b1;
    if (IR5_TO_D) p_d[FLAG_D] = IR5;
    p_d = p_canon(p_d);
  end

  // State registers; I_MASK follows I only at boundaries, except on interrupt entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_q       <= p_canon(RESET_P);
      i_mask_q  <= RESET_P[FLAG_I];
      hc_last_q <= 1'b0;
    end else if (CE) begin
      p_q <= p_d;
      if (SYNC || ONE_TO_I) i_mask_q  <= p_d[FLAG_I];
      if (ACR_TO_C)         hc_last_q <= HC_IN;
    end
  end

  assign P_OUT   = p_q;
  assign I_MASK  = i_mask_q;
  assign D_FLAG  = p_q[FLAG_D];
  assign HC_LAST = hc_last_q;
  assign DB_OE   = P_TO_DB;
  assign DB_OUT  = P_TO_DB ? {p_q[7:5], BRK_PUSH, p_q[3:0]} : 8'h00;

endmodule

// File: tb/tb_processor_status_reg.sv
// Randomized self-checking bench for processor_status_reg against a flag-level
// reference model; SO pin scenario runs when SO_PIN_EN is defined.
module tb_processor_status_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce, avr_in, acr_in, hc_in, ir5;
  logic [7:0] db_in;
  logic       db_to_p, acr_to_c, ir5_to_c, db0_to_c, avr_to_v, db6_to_v, zero_v;
  logic       dbz_to_z, db7_to_n, ir5_to_i, one_to_i, ir5_to_d, sync, brk_push, p_to_db;
  logic       so_n = 1'b1;
  logic [7:0] db_out, p_out;
  logic       db_oe, i_mask, d_flag, hc_last;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Reference model: architectural flags held as individual bits.
  logic m_n, m_v, m_d, m_i, m_z, m_c, m_imask, m_hc;

  processor_status_reg dut (
    .CLK(clk), .RST(rst), .CE(ce), .DB_IN(db_in), .AVR_IN(avr_in), .ACR_IN(acr_in),
    .HC_IN(hc_in), .IR5(ir5), .DB_TO_P(db_to_p), .ACR_TO_C(acr_to_c), .IR5_TO_C(ir5_to_c),
    .DB0_TO_C(db0_to_c), .AVR_TO_V(avr_to_v), .DB6_TO_V(db6_to_v), .ZERO_V(zero_v),
    .DBZ_TO_Z(dbz_to_z), .DB7_TO_N(db7_to_n), .IR5_TO_I(ir5_to_i), .ONE_TO_I(one_to_i),
    .IR5_TO_D(ir5_to_d), .SYNC(sync), .BRK_PUSH(brk_push), .P_TO_DB(p_to_db),
`ifdef SO_PIN_EN
    .SO_N(so_n),
`endif
    .DB_OUT(db_out), .DB_OE(db_oe), .P_OUT(p_out), .I_MASK(i_mask), .D_FLAG(d_flag),
    .HC_LAST(hc_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    else n_pass++;
  endtask

  // First enabled source in a priority list (index 0 = highest) wins.
  function automatic logic pick(input logic [4:0] en, input logic [4:0] val, input logic cur);
    logic r;
    logic found;
    r = cur;
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (!found && en[k]) begin
        r = val[k];
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] m_p();
    return {m_n, m_v, 1'b1, 1'b0, m_d, m_i, m_z, m_c};
  endfunction

  task automatic model_reset();
    {m_n, m_v, m_d, m_i, m_z, m_c} = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    m_imask = 1'b1;
    m_hc    = 1'b0;
  endtask

  task automatic model_step(input logic so_fall);
    logic ni;
    if (ce) begin
      m_c = pick({1'b0, db_to_p, ir5_to_c, db0_to_c, acr_to_c},
                 {1'b0, db_in[0], ir5, db_in[0], acr_in}, m_c);
      m_v = pick({db_to_p, db6_to_v, avr_to_v, zero_v, so_fall},
                 {db_in[6], db_in[6], avr_in, 1'b0, 1'b1}, m_v);
      m_z = pick({3'b0, db_to_p, dbz_to_z}, {3'b0, db_in[1], db_in == 8'h00}, m_z);
      m_n = pick({3'b0, db_to_p, db7_to_n}, {3'b0, db_in[7], db_in[7]}, m_n);
      ni  = pick({2'b0, db_to_p, ir5_to_i, one_to_i}, {2'b0, db_in[2], ir5, 1'b1}, m_i);
      m_d = pick({3'b0, db_to_p, ir5_to_d}, {3'b0, db_in[3], ir5}, m_d);
      m_i = ni;
      if (sync || one_to_i) m_imask = ni;
      if (acr_to_c) m_hc = hc_in;
    end
  endtask

  task automatic idle_inputs();
    ce = 1'b1; db_in = 8'h00; avr_in = 1'b0; acr_in = 1'b0; hc_in = 1'b0; ir5 = 1'b0;
    {db_to_p, acr_to_c, ir5_to_c, db0_to_c, avr_to_v, db6_to_v, zero_v} = '0;
    {dbz_to_z, db7_to_n, ir5_to_i, one_to_i, ir5_to_d, sync, brk_push, p_to_db} = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_p"},     p_out,         m_p());
    check({tag, "_imask"}, 8'(i_mask),    8'(m_imask));
    check({tag, "_d"},     8'(d_flag),    8'(m_d));
    check({tag, "_hc"},    8'(hc_last),   8'(m_hc));
  endtask

  // One CE cycle: check the push path on the pre-update P, then advance and compare.
  task automatic cycle(input string tag, input logic so_fall);
    logic [7:0] exp_db;
    #1;
    exp_db = p_to_db ? {m_n, m_v, 1'b1, brk_push, m_d, m_i, m_z, m_c} : 8'h00;
    check({tag, "_dbout"}, db_out,     exp_db);
    check({tag, "_dboe"},  8'(db_oe),  8'(p_to_db));
    model_step(so_fall);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs(tag);
    check({tag, "_dbout"}, db_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    #13;
    async_reset("reset");
    check("reset_p_const", p_out, 8'h24);

    // ADC-style flag update
    db_in = 8'h00; acr_in = 1'b1; avr_in = 1'b1; hc_in = 1'b1;
    acr_to_c = 1'b1; avr_to_v = 1'b1; dbz_to_z = 1'b1; db7_to_n = 1'b1;
    cycle("adc", 1'b0);
    check("adc_p_const", p_out, 8'h67);
    check("adc_hc_const", 8'(hc_last), 8'h01);

    // CLI: I clears now, I_MASK waits for the boundary
    idle_inputs(); ir5 = 1'b0; ir5_to_i = 1'b1;
    cycle("cli", 1'b0);
    check("cli_imask_hold", 8'(i_mask), 8'h01);
    idle_inputs(); sync = 1'b1;
    cycle("cli_sync", 1'b0);
    check("cli_imask_clr", 8'(i_mask), 8'h00);
    idle_inputs(); one_to_i = 1'b1;
    cycle("irq_entry", 1'b0);
    check("irq_imask_set", 8'(i_mask), 8'h01);

    // PLP then push with B
    idle_inputs(); db_in = 8'hFF; db_to_p = 1'b1;
    cycle("plp", 1'b0);
    check("plp_p_const", p_out, 8'hEF);
    idle_inputs(); ce = 1'b0; p_to_db = 1'b1; brk_push = 1'b1;
    cycle("push", 1'b0);
    check("push_db_const", db_out, 8'hFF);

    // Priority cases and CE freeze
    idle_inputs(); acr_in = 1'b0; acr_to_c = 1'b1; db_in = 8'h01; db0_to_c = 1'b1;
    cycle("prio_c", 1'b0);
    check("prio_c_const", 8'(p_out[0]), 8'h00);
    idle_inputs(); zero_v = 1'b1; avr_in = 1'b1; avr_to_v = 1'b1;
    cycle("prio_v", 1'b0);
    check("prio_v_const", 8'(p_out[6]), 8'h00);
    idle_inputs(); ce = 1'b0; db_in = 8'h5A; ir5 = 1'b1; acr_in = 1'b1; avr_in = 1'b1;
    {db_to_p, acr_to_c, ir5_to_c, db0_to_c, avr_to_v, db6_to_v, zero_v} = '1;
    {dbz_to_z, db7_to_n, ir5_to_i, one_to_i, ir5_to_d, sync} = '1;
    cycle("ce_freeze", 1'b0);

    // Randomized traffic with occasional mid-cycle resets
    for (int t = 0; t < 400; t++) begin
      idle_inputs();
      if ($urandom_range(0, 63) == 0) begin
        #2;
        async_reset("rnd_reset");
        continue;
      end
      ce = ($urandom_range(0, 3) != 0);
      db_in = 8'($urandom);
      if ($urandom_range(0, 5) == 0) db_in = 8'h00;
      {avr_in, acr_in, hc_in, ir5, brk_push, p_to_db} = 6'($urandom);
      db_to_p  = ($urandom_range(0, 5) == 0);
      acr_to_c = ($urandom_range(0, 3) == 0);
      ir5_to_c = ($urandom_range(0, 5) == 0);
      db0_to_c = ($urandom_range(0, 5) == 0);
      avr_to_v = ($urandom_range(0, 3) == 0);
      db6_to_v = ($urandom_range(0, 5) == 0);
      zero_v   = ($urandom_range(0, 7) == 0);
      dbz_to_z = ($urandom_range(0, 3) == 0);
      db7_to_n = ($urandom_range(0, 3) == 0);
      ir5_to_i = ($urandom_range(0, 5) == 0);
      one_to_i = ($urandom_range(0, 9) == 0);
      ir5_to_d = ($urandom_range(0, 5) == 0);
      sync     = ($urandom_range(0, 3) == 0);
      cycle("rnd", 1'b0);
    end

`ifdef SO_PIN_EN
    // SO pin: V sets on the third CE edge after the fall, and only once
    idle_inputs(); zero_v = 1'b1;
    cycle("so_pre", 1'b0);
    idle_inputs();
    so_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cycle("so_hold", k == 3);
      check("so_v_timing", 8'(p_out[6]), (k >= 3) ? 8'h01 : 8'h00);
    end
    zero_v = 1'b1;
    cycle("so_clv", 1'b0);
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      cycle("so_low", 1'b0);
      check("so_v_stays0", 8'(p_out[6]), 8'h00);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
